csr_mux_demux_n: RTL

- Parametrised N-port CSR router between one core CSR request/response port and NumPorts accelerator CSR ports.
- Decodes each request address into a port index by contiguous register ranges, forwards it with the base offset removed, and records the port index of every read in an ordered tracking FIFO.
- Steers read responses back strictly in request order, with bounded outstanding reads.
- Out-of-range accesses are absorbed internally.

---
 rtl/csr_mux_demux_pkg.sv | 36 +++
 rtl/csr_rsp_order_fifo.sv | 52 +++++
 rtl/csr_mux_demux_n.sv | 101 ++++++++++
 3 files changed

// File: rtl/csr_mux_demux_pkg.sv
// rtl/csr_mux_demux_pkg.sv - shared types and address decode for the CSR router
package csr_mux_demux_pkg;

    localparam int unsigned NUM_PORTS       = 4;
    localparam int unsigned REGS_PER_PORT   = 8;
    localparam int unsigned REG_DATA_WIDTH  = 32;
    localparam int unsigned MAX_OUTSTANDING = 4;
    localparam int unsigned SEL_WIDTH       = $clog2(NUM_PORTS + 1);
    localparam int unsigned PORT_ADDR_WIDTH = $clog2(REGS_PER_PORT);
    localparam int unsigned ADDR_WIDTH      = $clog2(NUM_PORTS * REGS_PER_PORT) + 1;

    typedef logic [SEL_WIDTH-1:0]       sel_t;
    typedef logic [PORT_ADDR_WIDTH-1:0] local_addr_t;

    typedef struct packed {
        logic oor;
        sel_t sel;
    } track_entry_t;

    typedef struct packed {
        logic        oor;
        sel_t        sel;
        local_addr_t local_addr;
    } decode_t;

    function automatic decode_t csr_decode(input logic [ADDR_WIDTH-1:0] addr);
        int unsigned sel_full;
        decode_t     d;
        sel_full     = 32'(addr) / REGS_PER_PORT;
        d.oor        = (sel_full >= NUM_PORTS);
        d.sel        = sel_t'(sel_full);
        d.local_addr = local_addr_t'(32'(addr) - sel_full * REGS_PER_PORT);
        return d;
    endfunction

endpackage

// File: rtl/csr_rsp_order_fifo.sv
// rtl/csr_rsp_order_fifo.sv - circular tracking FIFO holding the port of each outstanding read
module csr_rsp_order_fifo #(
    parameter int unsigned Width = 4,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [Depth-1:0][Width-1:0]   mem_q, mem_d;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign data_o  = mem_q[rd_ptr_q[PtrW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i && !full_o) begin
            mem_d[wr_ptr_q[PtrW-1:0]] = data_i;
            wr_ptr_d                  = wr_ptr_q + 1'b1;
        end
        if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/csr_mux_demux_n.sv
// rtl/csr_mux_demux_n.sv - routes core CSR requests to N accelerator ports by address range
// and returns read responses in request order.
module csr_mux_demux_n
    import csr_mux_demux_pkg::*;
#(
    parameter int unsigned NumPorts       = NUM_PORTS,
    parameter int unsigned RegsPerPort    = REGS_PER_PORT,
    parameter int unsigned RegDataWidth   = REG_DATA_WIDTH,
    parameter int unsigned MaxOutstanding = MAX_OUTSTANDING,
    parameter int unsigned AddrWidth      = $clog2(NumPorts * RegsPerPort) + 1,
    parameter int unsigned PortAddrWidth  = $clog2(RegsPerPort)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [AddrWidth-1:0]                   csr_addr_i,
    input  logic [RegDataWidth-1:0]                csr_wr_data_i,
    input  logic                                   csr_wr_en_i,
    input  logic                                   csr_req_valid_i,
    output logic                                   csr_req_ready_o,
    output logic [RegDataWidth-1:0]                csr_rd_data_o,
    output logic                                   csr_rsp_valid_o,
    input  logic                                   csr_rsp_ready_i,
    output logic [NumPorts-1:0][PortAddrWidth-1:0] acc_csr_addr_o,
    output logic [NumPorts-1:0][RegDataWidth-1:0]  acc_csr_wr_data_o,
    output logic [NumPorts-1:0]                    acc_csr_wr_en_o,
    output logic [NumPorts-1:0]                    acc_csr_req_valid_o,
    input  logic [NumPorts-1:0]                    acc_csr_req_ready_i,
    input  logic [NumPorts-1:0][RegDataWidth-1:0]  acc_csr_rd_data_i,
    input  logic [NumPorts-1:0]                    acc_csr_rsp_valid_i,
    output logic [NumPorts-1:0]                    acc_csr_rsp_ready_o
);

    decode_t      dec;
    track_entry_t push_entry;
    track_entry_t head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         block;
    logic         port_ready;
    logic         push;
    logic         pop;

    assign dec        = csr_decode(csr_addr_i);
    assign block      = ~csr_wr_en_i & fifo_full;
    assign push_entry = '{oor: dec.oor, sel: dec.sel};
    assign push       = csr_req_valid_i & csr_req_ready_o & ~csr_wr_en_i;
    assign pop        = csr_rsp_valid_o & csr_rsp_ready_i;

    always_comb begin
        acc_csr_addr_o      = '0;
        acc_csr_wr_data_o   = '0;
        acc_csr_wr_en_o     = '0;
        acc_csr_req_valid_o = '0;
        port_ready          = 1'b0;
        for (int p = 0; p < NumPorts; p++) begin
            if (!dec.oor && dec.sel == sel_t'(p)) begin
                acc_csr_addr_o[p]      = dec.local_addr;
                acc_csr_wr_data_o[p]   = csr_wr_data_i;
                acc_csr_wr_en_o[p]     = csr_wr_en_i;
                acc_csr_req_valid_o[p] = csr_req_valid_i & ~block;
                port_ready             = acc_csr_req_ready_i[p];
            end
        end
        // Out-of-range accesses are absorbed here, so they only wait on the FIFO.
        csr_req_ready_o = (dec.oor | port_ready) & ~block;
    end

    always_comb begin
        csr_rsp_valid_o     = 1'b0;
        csr_rd_data_o       = '0;
        acc_csr_rsp_ready_o = '0;
        if (!fifo_empty) begin
            if (head.oor) begin
                csr_rsp_valid_o = 1'b1;
            end else begin
                for (int p = 0; p < NumPorts; p++) begin
                    if (head.sel == sel_t'(p)) begin
                        csr_rsp_valid_o        = acc_csr_rsp_valid_i[p];
                        csr_rd_data_o          = acc_csr_rd_data_i[p];
                        acc_csr_rsp_ready_o[p] = csr_rsp_ready_i;
                    end
                end
            end
        end
    end

    csr_rsp_order_fifo #(
        .Width ($bits(track_entry_t)),
        .Depth (MaxOutstanding)
    ) u_order_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
